// File: rtl/ahb_apb_multi_bridge.sv
// AHB-lite slave to multi-slave APB bridge: one outstanding transfer, slave picked
// from an HADDR bit field, two-cycle AHB ERROR on bad index, PSLVERR or timeout.
module ahb_apb_multi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = 4,
    parameter int SLV_LSB    = 12,
    parameter int TIMEOUT    = 0
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          HSEL,
    input  logic [ADDR_WIDTH-1:0]         HADDR,
    input  logic [1:0]                    HTRANS,
    input  logic                          HWRITE,
    input  logic [DATA_WIDTH-1:0]         HWDATA,
    input  logic                          HREADY,
    output logic [DATA_WIDTH-1:0]         HRDATA,
    output logic                          HRESP,
    output logic                          HREADYOUT,
    output logic [NUM_SLV-1:0]            PSEL,
    output logic                          PENABLE,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic                          PWRITE,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]            PREADY,
    input  logic [NUM_SLV-1:0]            PSLVERR
);
    localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [SW-1:0]         idx;
    } req_t;

    state_t                  state, state_d;
    req_t                    req;
    logic [CW-1:0]           wait_cnt;
    logic                    accept, hidx_bad, sel_ready, sel_err, timeout_hit;
    logic [SW-1:0]           hidx;
    logic [31:0]             hidx_ext;
    logic [NUM_SLV-1:0]      dec;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    assign accept   = HSEL & HTRANS[1] & HREADY & ((state == IDLE) | (state == ERR2));
    assign hidx     = HADDR[SLV_LSB +: SW];
    assign hidx_ext = 32'(hidx);
    assign hidx_bad = (hidx_ext >= NUM_SLV);

    // Slave decode from the captured index; an out-of-range index never reaches SETUP.
    for (genvar i = 0; i < NUM_SLV; i++) begin : g_dec
        assign dec[i] = (req.idx == SW'(i));
    end

    assign sel_ready = |(PREADY & dec);
    assign sel_err   = |(PSLVERR & dec);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++)
            if (dec[i]) sel_rdata = sel_rdata | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state;
        case (state)
            IDLE, ERR2: begin
                if (!accept)       state_d = IDLE;
                else if (hidx_bad) state_d = ERR1;
                else if (HWRITE)   state_d = WDATA;
                else               state_d = SETUP;
            end
            WDATA:  state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (sel_ready)        state_d = sel_err ? ERR1 : IDLE;
                else if (timeout_hit) state_d = ERR1;
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            req      <= '0;
            PADDR    <= '0;
            PWRITE   <= 1'b0;
            PWDATA   <= '0;
            HRDATA   <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_d;
            if (accept)
                req <= '{addr: HADDR, write: HWRITE, idx: hidx};
            if (state == WDATA)
                PWDATA <= HWDATA;
            // Reads skip WDATA, so their APB address comes straight off the AHB bus.
            if (state_d == SETUP) begin
                PADDR    <= (state == WDATA) ? req.addr  : HADDR;
                PWRITE   <= (state == WDATA) ? req.write : HWRITE;
                wait_cnt <= '0;
            end else if (state == ACCESS && !sel_ready && TIMEOUT > 0) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (state == ACCESS && sel_ready && !sel_err && !req.write)
                HRDATA <= sel_rdata;
        end
    end

    assign PSEL      = (state == SETUP || state == ACCESS) ? dec : '0;
    assign PENABLE   = (state == ACCESS);
    assign HREADYOUT = (state == IDLE) || (state == ERR2);
    assign HRESP     = (state == ERR1) || (state == ERR2);

endmodule

// File: tb/tb_ahb_apb_multi_bridge.sv
// Directed bench for ahb_apb_multi_bridge (3 slaves, timeout 4) with a queue scoreboard
// checked by a monitor at each transfer completion.
module tb_ahb_apb_multi_bridge;
    logic        HCLK, HRESETn, HSEL, HWRITE, HREADY;
    logic [31:0] HADDR, HWDATA, HRDATA, PADDR, PWDATA;
    logic [1:0]  HTRANS;
    logic        HRESP, HREADYOUT, PENABLE, PWRITE;
    logic [2:0]  PSEL, PREADY, PSLVERR;
    logic [95:0] PRDATA;

    ahb_apb_multi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLV(3), .SLV_LSB(12), .TIMEOUT(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP),
        .HREADYOUT(HREADYOUT), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // APB slave model: PREADY after wait_n low ACCESS cycles unless stuck.
    logic [31:0] slv_data [3];
    int          wait_n, acc_cnt;
    logic        stuck, slv_err, ready_now;

    assign ready_now = PENABLE && !stuck && (acc_cnt >= wait_n);
    assign PREADY    = ready_now ? PSEL : 3'b000;
    assign PSLVERR   = (ready_now && slv_err) ? PSEL : 3'b000;
    assign PRDATA    = {slv_data[2], slv_data[1], slv_data[0]};

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)                    acc_cnt <= 0;
        else if (PENABLE && !ready_now)  acc_cnt <= acc_cnt + 1;
        else                             acc_cnt <= 0;
    end

    typedef struct {
        int          id;
        int          lo;
        int          pn;
        logic [2:0]  psel;
        int          en;
        logic        resp;
        logic [31:0] rdata;
        logic [31:0] paddr;
        logic        wr;
        logic [31:0] pwdata;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int lo, input int pn, input logic [2:0] ps, input int en,
                        input logic rs, input logic [31:0] rd, input logic [31:0] pa,
                        input logic wr, input logic [31:0] pw);
        exp_t e;
        e = '{id: id, lo: lo, pn: pn, psel: ps, en: en, resp: rs, rdata: rd, paddr: pa, wr: wr, pwdata: pw};
        q.push_back(e);
    endtask

    // Monitor: accumulates one busy window, compares when HREADYOUT returns high.
    int          m_lo, m_pn, m_en;
    logic [2:0]  m_por;
    logic [31:0] m_pa0, m_pw0;
    logic        m_unst_a, m_unst_w, m_lastr, m_busy;

    initial begin
        exp_t e;
        m_busy = 1'b0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                m_busy = 1'b0;
            end else if (!HREADYOUT) begin
                if (!m_busy) begin
                    m_busy = 1'b1; m_lo = 0; m_pn = 0; m_en = 0; m_por = '0;
                    m_unst_a = 1'b0; m_unst_w = 1'b0;
                end
                m_lo++;
                m_lastr = HRESP;
                if (PSEL != 3'b000) begin
                    if (m_pn == 0) begin
                        m_pa0 = PADDR; m_pw0 = PWDATA;
                    end else begin
                        if (PADDR !== m_pa0)  m_unst_a = 1'b1;
                        if (PWDATA !== m_pw0) m_unst_w = 1'b1;
                    end
                    m_pn++;
                    m_por = m_por | PSEL;
                end
                if (PENABLE) m_en++;
            end else if (m_busy) begin
                m_busy = 1'b0;
                if (q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("t%0d_hreadyout_low_cycles", e.id), m_lo, e.lo);
                    chk($sformatf("t%0d_psel_cycles", e.id), m_pn, e.pn);
                    chk($sformatf("t%0d_psel", e.id), m_por, e.psel);
                    chk($sformatf("t%0d_penable_cycles", e.id), m_en, e.en);
                    chk($sformatf("t%0d_hresp_first", e.id), m_lastr, e.resp);
                    chk($sformatf("t%0d_hresp_second", e.id), HRESP, e.resp);
                    chk($sformatf("t%0d_hrdata", e.id), HRDATA, e.rdata);
                    if (e.pn > 0) begin
                        chk($sformatf("t%0d_paddr", e.id), m_pa0, e.paddr);
                        chk($sformatf("t%0d_paddr_stable", e.id), m_unst_a, 0);
                    end
                    if (e.wr) begin
                        chk($sformatf("t%0d_pwdata", e.id), m_pw0, e.pwdata);
                        chk($sformatf("t%0d_pwdata_stable", e.id), m_unst_w, 0);
                    end
                end
            end
        end
    end

    task automatic slave_cfg(input int w, input logic err, input logic stk);
        wait_n = w; slv_err = err; stuck = stk;
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd);
        int n;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HREADY = 1'b1;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'hDEAD_3000; HWDATA = wd;
        n = 0;
        while (!HREADYOUT && n < 40) begin
            @(negedge HCLK);
            n++;
        end
        if (!HREADYOUT) chk("xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic ignored(input logic sel, input logic [1:0] tr, input logic rdy, input string name);
        @(negedge HCLK);
        HSEL = sel; HTRANS = tr; HADDR = 32'h0000_2000; HWRITE = 1'b0; HREADY = rdy;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
        chk({name, "_hreadyout"}, HREADYOUT, 1'b1);
        chk({name, "_psel"}, PSEL, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HWDATA = '0; HREADY = 1'b1;
        slv_data[0] = 32'hBAD0_0000; slv_data[1] = 32'h5555_AAAA; slv_data[2] = 32'hCAFE_0001;
        slave_cfg(0, 1'b0, 1'b0);
        #1;
        chk("rst_hreadyout", HREADYOUT, 1'b1);
        chk("rst_hresp", HRESP, 1'b0);
        chk("rst_psel", PSEL, 3'b000);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        ignored(1'b1, 2'b01, 1'b1, "ign_busy");
        ignored(1'b0, 2'b10, 1'b1, "ign_nosel");
        ignored(1'b1, 2'b10, 1'b0, "ign_nohready");

        // 1: read slave 2, no wait
        slave_cfg(0, 1'b0, 1'b0);
        push(1, 2, 2, 3'b100, 1, 1'b0, 32'hCAFE_0001, 32'h0000_2004, 1'b0, 32'h0);
        xfer(32'h0000_2004, 1'b0, 32'h0);
        // 2: write slave 1, three wait states
        slave_cfg(3, 1'b0, 1'b0);
        push(2, 6, 5, 3'b010, 4, 1'b0, 32'hCAFE_0001, 32'h0000_1010, 1'b1, 32'h1234_5678);
        xfer(32'h0000_1010, 1'b1, 32'h1234_5678);
        // 3: read slave 0 with PSLVERR
        slave_cfg(0, 1'b1, 1'b0);
        push(3, 3, 2, 3'b001, 1, 1'b1, 32'hCAFE_0001, 32'h0000_0008, 1'b0, 32'h0);
        xfer(32'h0000_0008, 1'b0, 32'h0);
        // 4: slave index 3 does not exist
        slave_cfg(0, 1'b0, 1'b0);
        push(4, 1, 0, 3'b000, 0, 1'b1, 32'hCAFE_0001, 32'h0, 1'b0, 32'h0);
        xfer(32'h0000_3000, 1'b0, 32'h0);
        // 5: slave 2 never ready, timeout after 4 ACCESS cycles
        slave_cfg(0, 1'b0, 1'b1);
        push(5, 6, 5, 3'b100, 4, 1'b1, 32'hCAFE_0001, 32'h0000_2100, 1'b0, 32'h0);
        xfer(32'h0000_2100, 1'b0, 32'h0);
        // 6: read slave 1, one wait state, HRDATA updates
        slave_cfg(1, 1'b0, 1'b0);
        push(6, 3, 3, 3'b010, 2, 1'b0, 32'h5555_AAAA, 32'h0000_1000, 1'b0, 32'h0);
        xfer(32'h0000_1000, 1'b0, 32'h0);

        // 7: reset pulsed mid-ACCESS
        slave_cfg(0, 1'b0, 1'b1);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_2000; HWRITE = 1'b0; HREADY = 1'b1;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        n = 0;
        while (!PENABLE && n < 10) begin
            @(negedge HCLK);
            n++;
        end
        chk("rst_mid_reach_access", PENABLE, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_mid_psel", PSEL, 3'b000);
        chk("rst_mid_penable", PENABLE, 1'b0);
        chk("rst_mid_hreadyout", HREADYOUT, 1'b1);
        chk("rst_mid_hresp", HRESP, 1'b0);
        chk("rst_mid_hrdata", HRDATA, 32'h0);
        chk("rst_mid_paddr", PADDR, 32'h0);
        chk("rst_mid_pwrite", PWRITE, 1'b0);
        chk("rst_mid_pwdata", PWDATA, 32'h0);
        repeat (2) @(negedge HCLK);
        slave_cfg(0, 1'b0, 1'b0);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst_mid_no_resume_psel", PSEL, 3'b000);
        chk("rst_mid_no_resume_rdy", HREADYOUT, 1'b1);

        // 8: normal read after reset
        push(8, 2, 2, 3'b100, 1, 1'b0, 32'hCAFE_0001, 32'h0000_2008, 1'b0, 32'h0);
        xfer(32'h0000_2008, 1'b0, 32'h0);

        repeat (3) @(negedge HCLK);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
